// File: rtl/spi_master_engine.sv
// spi_master_engine: SPI shift engine (4 CPOL/CPHA modes, MSB first, multi-word frames); define SPI_LOOPBACK_EN for MOSI->MISO loopback
module spi_master_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIVIDER_WIDTH = 32,
  parameter int WAIT_WIDTH    = 32,
  parameter int SLAVE_NUM     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     soft_rst_i,
  input  logic                     cpol_i,
  input  logic                     cpha_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic [WAIT_WIDTH-1:0]    wait_time_i,
  input  logic [SLAVE_NUM-1:0]     slave_select_i,
  input  logic [DATA_WIDTH-1:0]    tx_data_i,
  input  logic                     tx_last_i,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  output logic [DATA_WIDTH-1:0]    rx_data_o,
  output logic                     rx_last_o,
  output logic                     rx_valid_o,
  input  logic                     rx_ready_i,
  output logic                     busy_o,
  output logic                     spi_sclk_o,
  output logic                     spi_mosi_o,
  input  logic                     spi_miso_i,
`ifdef SPI_LOOPBACK_EN
  input  logic                     loopback_i,
`endif
  output logic [SLAVE_NUM-1:0]     spi_cs_n_o
);
  localparam int HP_W = $clog2(2 * DATA_WIDTH);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SETUP    = 3'd1;
  localparam logic [2:0] TRANSFER = 3'd2;
  localparam logic [2:0] RXPUSH   = 3'd3;
  localparam logic [2:0] NEXT     = 3'd4;
  localparam logic [2:0] HOLD     = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [DATA_WIDTH-1:0]    tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [DIVIDER_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [WAIT_WIDTH-1:0]    wait_q, wait_d, wcnt_q, wcnt_d;
  logic [SLAVE_NUM-1:0]     cs_n_q, cs_n_d, cs_sel;
  logic [HP_W-1:0]          hp_q, hp_d;
  logic                     last_q, last_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic                     sclk_q, sclk_d, mosi_q, mosi_d;
  logic                     rx_last_q, rx_last_d, rx_valid_q, rx_valid_d;
  logic                     tx_hs, half_done, lead, last_hp, sample_now, sample_bit, start;
  logic [DATA_WIDTH-1:0]    entry_word, rx_next;

`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_d;
  assign sample_bit = lb_q ? mosi_q : spi_miso_i;
  assign cs_sel     = loopback_i ? '1 : ~slave_select_i;
`else
  assign sample_bit = spi_miso_i;
  assign cs_sel     = ~slave_select_i;
`endif

  assign tx_ready_o = (state_q == IDLE || state_q == NEXT) && !soft_rst_i && !rst_i;
  assign tx_hs      = tx_valid_i && tx_ready_o;
  assign half_done  = cnt_q == div_q;
  assign lead       = !hp_q[0];
  assign last_hp    = hp_q == HP_W'(2 * DATA_WIDTH - 1);
  // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge shifts MOSI
  assign sample_now = lead ^ cpha_q;
  assign rx_next    = {rx_sr_q[DATA_WIDTH-2:0], sample_bit};
  assign entry_word = (state_q == NEXT) ? tx_data_i : tx_sr_q;

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    wcnt_d     = wcnt_q;
    cs_n_d     = cs_n_q;
    hp_d       = hp_q;
    last_d     = last_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    rx_last_d  = rx_last_q;
    rx_valid_d = rx_valid_q;
    start      = 1'b0;
`ifdef SPI_LOOPBACK_EN
    lb_d       = lb_q;
`endif
    case (state_q)
      IDLE: begin
        sclk_d = cpol_i;
        if (tx_hs) begin
          state_d = SETUP;
          tx_sr_d = tx_data_i;
          last_d  = tx_last_i;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          div_d   = clk_divider_i;
          wait_d  = wait_time_i;
          cs_n_d  = cs_sel;
          wcnt_d  = '0;
`ifdef SPI_LOOPBACK_EN
          lb_d    = loopback_i;
`endif
        end
      end
      SETUP: begin
        wcnt_d = wcnt_q + 1'b1;
        start  = wcnt_q == wait_q;
      end
      TRANSFER: begin
        cnt_d = half_done ? '0 : cnt_q + 1'b1;
        if (half_done) begin
          sclk_d = ~sclk_q;
          hp_d   = hp_q + 1'b1;
          if (sample_now) rx_sr_d = rx_next;
          else begin
            mosi_d  = tx_sr_q[DATA_WIDTH-1];
            tx_sr_d = tx_sr_q << 1;
          end
          if (last_hp) begin
            state_d    = RXPUSH;
            rx_valid_d = 1'b1;
            rx_last_d  = last_q;
            rx_data_d  = cpha_q ? rx_next : rx_sr_q;
          end
        end
      end
      RXPUSH: begin
        if (rx_ready_i) begin
          rx_valid_d = 1'b0;
          state_d    = last_q ? HOLD : NEXT;
          wcnt_d     = '0;
        end
      end
      NEXT: begin
        if (tx_hs) begin
          last_d = tx_last_i;
          start  = 1'b1;
        end
      end
      HOLD: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == wait_q) begin
          cs_n_d  = '1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // CPHA=0 presents the MSB before the first edge; CPHA=1 drives it on the first leading edge
    if (start) begin
      state_d = TRANSFER;
      cnt_d   = '0;
      hp_d    = '0;
      tx_sr_d = cpha_q ? entry_word : entry_word << 1;
      mosi_d  = cpha_q ? mosi_q : entry_word[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || soft_rst_i) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      wait_q     <= '0;
      wcnt_q     <= '0;
      cs_n_q     <= '1;
      hp_q       <= '0;
      last_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= cpol_i;
      mosi_q     <= 1'b0;
      rx_last_q  <= 1'b0;
      rx_valid_q <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lb_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      wcnt_q     <= wcnt_d;
      cs_n_q     <= cs_n_d;
      hp_q       <= hp_d;
      last_q     <= last_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rx_last_q  <= rx_last_d;
      rx_valid_q <= rx_valid_d;
`ifdef SPI_LOOPBACK_EN
      lb_q       <= lb_d;
`endif
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_last_o  = rx_last_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = state_q != IDLE;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign spi_cs_n_o = cs_n_q;
endmodule
